pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline: merges per-stage stall requests into a hold/bubble vector for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and sequences exception redirection. It guarantees that a fetch already in flight on the instruction bus is drained and discarded before the PC is redirected. It drives the stall and flush inputs of every pipeline register, including the IF/ID register, and keeps a stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: merges per-stage stall
// requests and sequences exception redirection behind any in-flight fetch.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_if,
    input  logic             req_id,
    input  logic             req_ex,
    input  logic             req_mem,
    input  logic             exc_valid,
    input  logic [31:0]      exc_target,
    input  logic             ibus_inflight,
    input  logic             ibus_done,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             ctrl_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [31:0]      tgt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             count_en;
    logic             latch_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            tgt_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= next_state;
            if (latch_tgt) tgt_q <= exc_target;
            if (count_en) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        stall       = 5'b00000;
        flush       = 5'b00000;
        pc_redirect = 1'b0;
        count_en    = 1'b0;
        latch_tgt   = 1'b0;
        if (rst) begin
            flush = 5'b11110;
        end else begin
            unique case (state)
                RUN: begin
                    if (exc_valid) begin
                        stall     = 5'b00001;
                        flush     = 5'b11110;
                        latch_tgt = 1'b1;
                        // A response arriving this same cycle leaves nothing to drain.
                        next_state = (ibus_inflight && !ibus_done) ? DRAIN : REDIRECT;
                    end else begin
                        if (req_mem)     stall = 5'b01111;
                        else if (req_ex) stall = 5'b00111;
                        else if (req_id) stall = 5'b00011;
                        else if (req_if) stall = 5'b00001;
                        // Insert a bubble where a held stage feeds a moving one.
                        flush    = {stall[3:0] & ~stall[4:1], 1'b0};
                        count_en = |stall;
                    end
                end
                DRAIN: begin
                    stall = 5'b00001;
                    flush = 5'b11110;
                    if (ibus_done) next_state = REDIRECT;
                end
                REDIRECT: begin
                    flush       = 5'b11110;
                    pc_redirect = 1'b1;
                    next_state  = RUN;
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    assign pc_target    = rst ? 32'h0 : tgt_q;
    assign ctrl_busy    = !rst && (state != RUN);
    assign stall_cycles = cnt_q;
    assign fsm_state    = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (4-bit stall counter).
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_if, req_id, req_ex, req_mem;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        ibus_inflight, ibus_done;
    logic [4:0]  stall, flush;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        ctrl_busy;
    logic [3:0]  stall_cycles;
    logic [1:0]  fsm_state;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_if(req_if), .req_id(req_id), .req_ex(req_ex), .req_mem(req_mem),
        .exc_valid(exc_valid), .exc_target(exc_target),
        .ibus_inflight(ibus_inflight), .ibus_done(ibus_done),
        .stall(stall), .flush(flush), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .ctrl_busy(ctrl_busy),
        .stall_cycles(stall_cycles), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_if = 0; req_id = 0; req_ex = 0; req_mem = 0;
        exc_valid = 0; exc_target = 32'h0;
        ibus_inflight = 0; ibus_done = 0;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] s, input logic [4:0] f,
                           input logic r, input logic b);
        @(negedge clk);
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".flush"}, 32'(flush), 32'(f));
        chk({tag, ".redirect"}, 32'(pc_redirect), 32'(r));
        chk({tag, ".busy"}, 32'(ctrl_busy), 32'(b));
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        req_mem = 1;
        chk_out("rst", 5'b00000, 5'b11110, 0, 0);
        chk("rst.target", pc_target, 32'h0);
        cyc();
        chk_out("rst2", 5'b00000, 5'b11110, 0, 0);
        chk("rst2.cnt", 32'(stall_cycles), 32'd0);
        chk("rst2.state", 32'(fsm_state), 32'd0);
        cyc();
        rst = 0;
        idle_inputs();
        chk_out("idle", 5'b00000, 5'b00000, 0, 0);
        chk("idle.cnt", 32'(stall_cycles), 32'd0);

        // Load-use stall held for three cycles.
        for (int i = 0; i < 3; i++) begin
            cyc();
            req_id = 1;
            chk_out("req_id", 5'b00011, 5'b00100, 0, 0);
            chk("req_id.cnt", 32'(stall_cycles), 32'(i));
        end
        cyc();
        idle_inputs();
        chk_out("req_id_end", 5'b00000, 5'b00000, 0, 0);
        chk("req_id_end.cnt", 32'(stall_cycles), 32'd3);

        // Priority: MEM beats IF; then EX alone; then IF alone.
        cyc();
        req_if = 1; req_mem = 1;
        chk_out("if_mem", 5'b01111, 5'b10000, 0, 0);
        cyc();
        idle_inputs(); req_ex = 1;
        chk_out("ex", 5'b00111, 5'b01000, 0, 0);
        cyc();
        idle_inputs(); req_if = 1;
        chk_out("if", 5'b00001, 5'b00010, 0, 0);
        cyc();
        idle_inputs();
        chk("prio.cnt", 32'(stall_cycles), 32'd6);

        // Exception with no fetch in flight, overriding a MEM stall.
        req_mem = 1; exc_valid = 1; exc_target = 32'hBFC00380;
        chk_out("exc0.T", 5'b00001, 5'b11110, 0, 0);
        cyc();
        idle_inputs(); req_mem = 1;
        chk_out("exc0.T1", 5'b00000, 5'b11110, 1, 1);
        chk("exc0.T1.target", pc_target, 32'hBFC00380);
        chk("exc0.T1.state", 32'(fsm_state), 32'd2);
        cyc();
        idle_inputs();
        chk_out("exc0.T2", 5'b00000, 5'b00000, 0, 0);
        chk("exc0.T2.cnt", 32'(stall_cycles), 32'd6);
        chk("exc0.T2.target", pc_target, 32'hBFC00380);

        // Exception with fetch in flight; response at T+4, redirect at T+5.
        cyc();
        exc_valid = 1; exc_target = 32'h80000180; ibus_inflight = 1;
        chk_out("exc1.T", 5'b00001, 5'b11110, 0, 0);
        for (int n = 1; n <= 4; n++) begin
            cyc();
            idle_inputs(); ibus_inflight = 1; req_ex = 1;
            ibus_done = (n == 4);
            chk_out("exc1.drain", 5'b00001, 5'b11110, 0, 1);
            chk("exc1.drain.state", 32'(fsm_state), 32'd1);
            chk("exc1.drain.target", pc_target, 32'h80000180);
        end
        cyc();
        idle_inputs();
        chk_out("exc1.T5", 5'b00000, 5'b11110, 1, 1);
        chk("exc1.T5.target", pc_target, 32'h80000180);
        cyc();
        chk_out("exc1.T6", 5'b00000, 5'b00000, 0, 0);
        chk("exc1.T6.cnt", 32'(stall_cycles), 32'd6);

        // Exception and fetch response in the same cycle: no drain.
        cyc();
        exc_valid = 1; exc_target = 32'h12345678; ibus_inflight = 1; ibus_done = 1;
        chk_out("exc2.T", 5'b00001, 5'b11110, 0, 0);
        cyc();
        idle_inputs();
        chk_out("exc2.T1", 5'b00000, 5'b11110, 1, 1);
        chk("exc2.T1.target", pc_target, 32'h12345678);
        cyc();
        chk_out("exc2.T2", 5'b00000, 5'b00000, 0, 0);

        // Reset in the second DRAIN cycle aborts the redirect.
        cyc();
        exc_valid = 1; exc_target = 32'hDEADBEEF; ibus_inflight = 1;
        chk_out("exc3.T", 5'b00001, 5'b11110, 0, 0);
        cyc();
        idle_inputs(); ibus_inflight = 1;
        chk_out("exc3.drain1", 5'b00001, 5'b11110, 0, 1);
        cyc();
        rst = 1;
        chk_out("exc3.rst", 5'b00000, 5'b11110, 0, 0);
        chk("exc3.rst.target", pc_target, 32'h0);
        cyc();
        rst = 0;
        idle_inputs();
        chk_out("exc3.after", 5'b00000, 5'b00000, 0, 0);
        chk("exc3.after.state", 32'(fsm_state), 32'd0);
        chk("exc3.after.cnt", 32'(stall_cycles), 32'd0);
        chk("exc3.after.target", pc_target, 32'h0);

        // 17 cycles of EX stall wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            cyc();
            req_ex = 1;
            chk_out("wrap", 5'b00111, 5'b01000, 0, 0);
        end
        cyc();
        idle_inputs();
        chk_out("wrap_end", 5'b00000, 5'b00000, 0, 0);
        chk("wrap_end.cnt", 32'(stall_cycles), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
